// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin two-port arbiter in front of a single-ported memory macro.
// Optional MEM_ARB_LOCK_EN adds R1_Lock so port 1 can hold priority for burst loads.
module memory_arbiter #(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 10
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 R0_Req,
    input  logic                 R0_We,
    input  logic [AddrWidth-1:0] R0_Addr,
    input  logic [DataWidth-1:0] R0_DIn,
    output logic                 R0_Gnt,
    output logic                 R0_Ack,
    input  logic                 R1_Req,
    input  logic                 R1_We,
    input  logic [AddrWidth-1:0] R1_Addr,
    input  logic [DataWidth-1:0] R1_DIn,
`ifdef MEM_ARB_LOCK_EN
    input  logic                 R1_Lock,
`endif
    output logic                 R1_Gnt,
    output logic                 R1_Ack,
    output logic [DataWidth-1:0] RData,
    output logic                 MEM_En,
    output logic                 MEM_Wr,
    output logic [AddrWidth-1:0] MEM_Addr,
    output logic [DataWidth-1:0] MEM_DIn,
    input  logic [DataWidth-1:0] MEM_DOut
);
    typedef enum logic [1:0] {S_Idle = 2'b00, S_Access = 2'b01} state_t;
    state_t state;
    logic   last;
    logic   lock_req;
    logic   pick1;
`ifdef MEM_ARB_LOCK_EN
    logic   lock_q;
    assign lock_req = lock_q && R1_Lock;
`else
    assign lock_req = 1'b0;
`endif
    // port 1 wins when alone, when port 0 went last, or while it holds the lock
    assign pick1 = R1_Req && (!R0_Req || !last || lock_req);
    always_ff @(posedge Clk) begin
        if (Reset || !(state inside {S_Idle, S_Access})) begin
            state    <= S_Idle;
            last     <= 1'b1;
            R0_Gnt   <= 1'b0;
            R1_Gnt   <= 1'b0;
            R0_Ack   <= 1'b0;
            R1_Ack   <= 1'b0;
            RData    <= '0;
            MEM_En   <= 1'b1;
            MEM_Wr   <= 1'b1;
            MEM_Addr <= '0;
            MEM_DIn  <= '0;
`ifdef MEM_ARB_LOCK_EN
            lock_q   <= 1'b0;
`endif
        end else if (state == S_Idle) begin
            R0_Ack <= 1'b0;
            R1_Ack <= 1'b0;
            if (R0_Req || R1_Req) begin
                state    <= S_Access;
                MEM_En   <= 1'b0;
                MEM_Wr   <= ~(pick1 ? R1_We : R0_We);
                MEM_Addr <= pick1 ? R1_Addr : R0_Addr;
                MEM_DIn  <= pick1 ? R1_DIn : R0_DIn;
                R0_Gnt   <= !pick1;
                R1_Gnt   <= pick1;
                last     <= pick1;
`ifdef MEM_ARB_LOCK_EN
                lock_q   <= pick1 && R1_Lock;
`endif
            end
        end else begin
            state  <= S_Idle;
            MEM_En <= 1'b1;
            MEM_Wr <= 1'b1;
            R0_Gnt <= 1'b0;
            R1_Gnt <= 1'b0;
            R0_Ack <= R0_Gnt;
            R1_Ack <= R1_Gnt;
            if (MEM_Wr) RData <= MEM_DOut;
        end
    end
endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single program/data memory between two requesters: port 0 = CPU sequencer (fetch/LD/ST/STX), port 1 = loader/debug master.
- Sits between the requesters and the memory macro. Drives the memory's active-low enable and its read-high/write-low strobe.
- Provides round-robin arbitration, latched transactions, and a one-cycle Ack per completed access.

Parameters:
- DataWidth, 16, memory word width.
- AddrWidth, 10, memory address width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- R0_Req  in  1  port 0 request, level, held until R0_Ack.
- R0_We  in  1  port 0 write (1) / read (0).
- R0_Addr  in  AddrWidth  port 0 address.
- R0_DIn  in  DataWidth  port 0 write data.
- R0_Gnt  out  1  port 0 owns memory.
- R0_Ack  out  1  port 0 access complete, 1-cycle pulse.
- R1_Req, R1_We, R1_Addr, R1_DIn, R1_Gnt, R1_Ack: same as port 0, for port 1.
- RData  out  DataWidth  registered read data, valid in the Ack cycle, held until the next read completes.
- MEM_En  out  1  memory enable, active low.
- MEM_Wr  out  1  1 = read, 0 = write.
- MEM_Addr  out  AddrWidth  memory address.
- MEM_DIn  out  DataWidth  memory write data.
- MEM_DOut  in  DataWidth  memory read data, valid in the enabled cycle before the next edge.

Behaviour:
- Clocking: one clock, Clk. Reset is synchronous and active-high. All outputs are registered.
- Reset values: Gnt=0, Ack=0, RData=0, MEM_En=1, MEM_Wr=1, MEM_Addr=0, MEM_DIn=0, state=S_Idle, Last=1 (so port 0 wins the first contention).
- S_Idle, no Req: remain in S_Idle. MEM_En=1.
- S_Idle, any Req at edge: choose winner W and go to S_Access.
  - Winner rule: the single requester if only one; if both, the port != Last.
  - Latch W's Addr/DIn/We into MEM_Addr/MEM_DIn/MEM_Wr (MEM_Wr = ~We).
  - Set MEM_En=0, Rx_Gnt=1 for W, Last=W.
- S_Access, next edge: go to S_Idle.
  - Set MEM_En=1, MEM_Wr=1, Gnt=0, and pulse Rx_Ack=1 for one cycle.
  - If read: RData<=MEM_DOut.
- Latency: Req seen at edge N → Gnt at N, memory access during cycle N..N+1, Ack/RData at N+1. Two cycles per transaction, minimum.
- Back-to-back: Req still high in the Ack cycle is a new request. A requester drops Req in the Ack cycle if done.
- The losing requester keeps Req high and is served next: worst-case wait is one transaction.
- Inputs are ignored while in S_Access: Req deassert, Addr/DIn/We changes, and the other port's Req. The latched transaction always completes.
- Gnt is never asserted on both ports. Ack is never asserted on both ports.
- Reset mid-S_Access: access aborted, no Ack, all outputs return to reset values next edge. RData is cleared to 0.
- Reset has priority over every transition.
- Unused state encodings go to S_Idle with reset output values.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Enabled: adds input R1_Lock (1 bit). If R1_Lock=1 when port 1 is granted, port 1 keeps priority over port 0 for following transactions while R1_Req && R1_Lock. Intended for burst program loads.
  - On R1_Lock falling, round-robin resumes with Last=1.
  - R1_Lock on a port-1 request while port 0 is mid-access waits for that access to finish.
- Disabled: no R1_Lock port, pure round-robin.

Test Plan:
1. Reset held 2 cycles, then R0_Req=1, R0_We=0, R0_Addr=0x005, MEM_DOut=0xA5A5 → R0_Gnt=1, MEM_En=0, MEM_Wr=1, MEM_Addr=0x005 next cycle. Then R0_Ack=1, RData=0xA5A5, MEM_En=1.
2. R1 write: R1_Req=1, R1_We=1, R1_Addr=0x3FF, R1_DIn=0x1234 → MEM_Wr=0, MEM_Addr=0x3FF, MEM_DIn=0x1234 for one cycle, then R1_Ack pulse. RData unchanged.
3. R0_Req and R1_Req both held high continuously after reset → grants alternate 0,1,0,1. Each port gets an Ack every 4 cycles, and no cycle has both Gnt bits high.
4. R0 read starts; R0_Addr changes to 0x010 and R0_Req drops during S_Access → MEM_Addr stays at the original value and R0_Ack still pulses.
5. Reset asserted in the S_Access cycle → no Ack. Next cycle MEM_En=1, Gnt=0, RData=0, and a subsequent contended request is granted to port 0.
6. (MEM_ARB_LOCK_EN) R1_Lock=1 with 3 consecutive R1 writes while R0_Req=1 → 3 R1 Acks before R0_Gnt. After R1_Lock=0, R0 is granted next.
